// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: access-size codes, LSU FSM states and lane helpers shared by
// lsu_ctrl and lsu_lane.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_R = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_e;

  function automatic logic [4:0] lane_shift(input logic [1:0] lo);
    return {lo, 3'b000};
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte/half lane logic; extracts and extends load data
// and merges sub-word store data into the word read from RAM.
module lsu_lane
  import lsu_ctrl_pkg::*;
(
  input  size_e       size,
  input  logic        sgn,
  input  logic [1:0]  lo,
  input  logic [31:0] rd_word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [15:0] shifted;
  logic [31:0] mask;
  logic [31:0] ins;

  always_comb begin
    shifted   = 16'(rd_word >> lane_shift(lo));
    mask      = '0;
    ins       = '0;
    load_data = rd_word;
    unique case (size)
      SZ_B: begin
        load_data = {{24{sgn & shifted[7]}}, shifted[7:0]};
        mask      = 32'h0000_00FF;
        ins       = {24'b0, wdata[7:0]};
      end
      SZ_H: begin
        load_data = {{16{sgn & shifted[15]}}, shifted};
        mask      = 32'h0000_FFFF;
        ins       = {16'b0, wdata};
      end
      default: ;
    endcase
    store_word = (rd_word & ~(mask << lane_shift(lo))) | (ins << lane_shift(lo));
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: valid/ready load/store unit driving a word-wide single-port data RAM.
// Define LSU_ERR_EN to enable misalignment / range / reserved-size error responses.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  size_e       size_q, size_d, size_n;
  logic        sgn_q, sgn_d;
  logic [1:0]  lo_q, lo_d, lo_n;
  logic [15:0] wdata_q, wdata_d;
  logic        acc_err;
  logic [31:0] load_data, store_word;

`ifdef LSU_ERR_EN
  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  always_comb begin
    size_n  = size_e'(req_size);
    lo_n    = req_addr[1:0];
    acc_err = (size_n == SZ_H && req_addr[0]) ||
              (size_n == SZ_W && req_addr[1:0] != 2'b00) ||
              (size_n == SZ_R) ||
              (req_addr >= ADDR_LIMIT);
  end
`else
  logic [31:0] unused_mem_words;
  assign unused_mem_words = 32'(MEM_WORDS);

  // Unchecked build: force natural alignment and treat the reserved size as a word.
  always_comb begin
    size_n  = (req_size == 2'b11) ? SZ_W : size_e'(req_size);
    acc_err = 1'b0;
    unique case (size_n)
      SZ_B:    lo_n = req_addr[1:0];
      SZ_H:    lo_n = {req_addr[1], 1'b0};
      default: lo_n = 2'b00;
    endcase
  end
`endif

  lsu_lane u_lane (
    .size       (size_q),
    .sgn        (sgn_q),
    .lo         (lo_q),
    .rd_word    (mem_rd),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_d    = 1'b0;
    mem_a_d     = mem_a_q;
    mem_wd_d    = mem_wd_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    lo_d        = lo_q;
    wdata_d     = wdata_q;
    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          size_d      = size_n;
          sgn_d       = req_signed;
          lo_d        = lo_n;
          wdata_d     = req_wdata[15:0];
          if (acc_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (!req_we) begin
            state_d = LOAD;
            mem_a_d = {req_addr[31:2], 2'b00};
          end else if (size_n == SZ_W) begin
            state_d  = WRITE;
            mem_we_d = 1'b1;
            mem_a_d  = {req_addr[31:2], 2'b00};
            mem_wd_d = req_wdata;
          end else begin
            state_d = RMW_RD;
            mem_a_d = {req_addr[31:2], 2'b00};
          end
        end
      end
      LOAD: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = load_data;
        mem_a_d     = '0;
      end
      RMW_RD: begin
        state_d  = WRITE;
        mem_we_d = 1'b1;
        mem_wd_d = store_word;
      end
      WRITE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        mem_a_d     = '0;
        mem_wd_d    = '0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_a_q     <= '0;
      mem_wd_q    <= '0;
      size_q      <= SZ_B;
      sgn_q       <= 1'b0;
      lo_q        <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_we_q    <= mem_we_d;
      mem_a_q     <= mem_a_d;
      mem_wd_q    <= mem_wd_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      lo_q        <= lo_d;
      wdata_q     <= wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_we    = mem_we_q;
  assign mem_a     = mem_a_q;
  assign mem_wd    = mem_wd_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl with a MEM_WORDS-word RAM model
// (async read, posedge write); honours LSU_ERR_EN like the design.
module tb_lsu_ctrl;

  localparam int unsigned MEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] ram [MEM_WORDS];
  logic        init_ram = 1'b1;
  int          we_cnt = 0;
  int          n_chk = 0;
  int          n_err = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  lsu_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = (mem_a < 32'(MEM_WORDS * 4)) ? ram[mem_a[7:2]] : '0;

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) ram[i] <= '0;
      ram[0] <= 32'h1122_3344;
      ram[1] <= 32'h1234_5678;
      ram[3] <= 32'hCAFE_F00D;
    end else if (mem_we) begin
      ram[mem_a[7:2]] <= mem_wd;
      we_cnt <= we_cnt + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Called one negedge after the accept edge; pops and compares at the response.
  task automatic wait_rsp(input string tag, input int we0, input int exp_we);
    int   lat;
    exp_t e;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    chk({tag, "_vld"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_rd"}, rsp_rdata, e.rdata);
    chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
    chk({tag, "_we"}, 32'(we_cnt - we0), 32'(exp_we));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_ret"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic issue(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_er, input int exp_lat, input int exp_we);
    int   we0;
    exp_t e;
    e.rdata = exp_rd;
    e.err   = exp_er;
    e.lat   = exp_lat;
    sb_q.push_back(e);
    chk({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    we0        = we_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(tag, we0, exp_we);
  endtask

  initial begin
    int   we0;
    exp_t e;

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_ctl", {29'b0, rsp_valid, rsp_err, mem_we}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    init_ram = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    chk("rel_ready", {31'b0, req_ready}, 32'd1);

    issue("sw", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1);
    chk("sw_ram", ram[2], 32'hDEAD_BEEF);
    issue("sb", 1'b1, 2'b00, 1'b0, 32'h09, 32'hFFFF_FF55, 32'h0, 1'b0, 3, 1);
    chk("sb_ram", ram[2], 32'hDEAD_55EF);
    issue("lb", 1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, 32'hFFFF_FFDE, 1'b0, 2, 0);
    issue("lbu", 1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, 32'h0000_00DE, 1'b0, 2, 0);
    issue("lh", 1'b0, 2'b01, 1'b1, 32'h08, 32'h0, 32'h0000_55EF, 1'b0, 2, 0);
    issue("lh_hi", 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 32'hFFFF_DEAD, 1'b0, 2, 0);
    issue("lhu_hi", 1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, 32'h0000_DEAD, 1'b0, 2, 0);
    issue("sh_hi", 1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234_A5A5, 32'h0, 1'b0, 3, 1);
    chk("sh_ram", ram[3], 32'hA5A5_F00D);

`ifdef LSU_ERR_EN
    issue("lw_mis", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1, 0);
    issue("sh_mis", 1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFF, 32'h0, 1'b1, 1, 0);
    issue("lw_oor", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0);
    issue("rsv", 1'b0, 2'b11, 1'b0, 32'h04, 32'h0, 32'h0, 1'b1, 1, 0);
    chk("err_ram0", ram[0], 32'h1122_3344);
    chk("err_ram1", ram[1], 32'h1234_5678);
`else
    issue("lw_06", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h1234_5678, 1'b0, 2, 0);
    issue("rsv_w", 1'b0, 2'b11, 1'b0, 32'h04, 32'h0, 32'h1234_5678, 1'b0, 2, 0);
`endif

    // Stalled consumer: response held, requests in the window ignored.
    we0 = we_cnt;
    e.rdata = 32'hDEAD_55EF;
    e.err   = 1'b0;
    e.lat   = 2;
    sb_q.push_back(e);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h08;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("stl_vld", {31'b0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      req_valid = (i == 2);
      req_we    = 1'b1;
      req_size  = 2'b10;
      req_addr  = 32'h0;
      req_wdata = 32'hBAD0_BAD0;
      @(negedge clk);
      chk("stl_vld_h", {31'b0, rsp_valid}, 32'd1);
      chk("stl_rd_h", rsp_rdata, 32'hDEAD_55EF);
      chk("stl_rdy", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    e = sb_q.pop_front();
    chk("stl_rd", rsp_rdata, e.rdata);
    chk("stl_err", {31'b0, rsp_err}, {31'b0, e.err});

    // Retire and present a new request in the same cycle.
    e.rdata = 32'h0000_00DE;
    e.err   = 1'b0;
    e.lat   = 2;
    sb_q.push_back(e);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h0B;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ovl_ret", {31'b0, rsp_valid}, 32'd0);
    chk("ovl_rdy", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp("ovl", we0, 0);
    chk("stl_ram0", ram[0], 32'h1122_3344);

    // Reset during the WRITE cycle of a byte store.
    we0 = we_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h0C; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    chk("r6_rmw_we", {31'b0, mem_we}, 32'd0);
    chk("r6_mem_a", mem_a, 32'h0C);
    @(negedge clk);
    chk("r6_we", {31'b0, mem_we}, 32'd1);
    chk("r6_wd", mem_wd, 32'hA5A5_F077);
    reset = 1'b1;
    #1;
    chk("r6_we0", {31'b0, mem_we}, 32'd0);
    chk("r6_ctl", {28'b0, req_ready, rsp_valid, rsp_err, mem_we}, 32'd0);
    chk("r6_a", mem_a, 32'd0);
    chk("r6_wd0", mem_wd, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("r6_ram", ram[3], 32'hA5A5_F00D);
    chk("r6_wecnt", 32'(we_cnt - we0), 32'd0);
    @(negedge clk);
    chk("r6_rdy", {31'b0, req_ready}, 32'd1);
    chk("r6_norsp", {31'b0, rsp_valid}, 32'd0);
    issue("lw_after", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hA5A5_F00D, 1'b0, 2, 0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
